// File: rtl/basicio_debounce.sv
// Push-button conditioner: per-bit synchroniser, stability-counter debounce, edge pulses.
// Optional auto-repeat pulses are compiled in with `define BASICIO_AUTOREPEAT_EN.
module basicio_debounce #(
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned REPEAT_WIDTH    = 25
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  output logic [NUM_BUTTONS-1:0] button_clean,
  output logic [NUM_BUTTONS-1:0] button_rise,
  output logic [NUM_BUTTONS-1:0] button_fall,
  output logic                   button_change,
  output logic [NUM_BUTTONS-1:0] button_repeat
);

  localparam logic [CNT_WIDTH-1:0] DEB_LIM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("basicio_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || ((DEBOUNCE_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_deb
    $error("basicio_debounce: DEBOUNCE_CYCLES-1 must fit in CNT_WIDTH and be >= 0");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_WIDTH < 1 ||
      ((REPEAT_DELAY - 1) >> REPEAT_WIDTH) != 0 ||
      ((REPEAT_PERIOD - 1) >> REPEAT_WIDTH) != 0) begin : g_bad_rep
    $error("basicio_debounce: repeat limits must fit in REPEAT_WIDTH");
  end

  logic [SYNC_STAGES-1:0][NUM_BUTTONS-1:0] sync_q, sync_d;
  logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]                  clean_q, clean_d;
  logic [NUM_BUTTONS-1:0]                  rise_q, rise_d;
  logic [NUM_BUTTONS-1:0]                  fall_q, fall_d;
  logic                                    change_q, change_d;
  logic [NUM_BUTTONS-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchroniser shift and per-bit debounce next state
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], button_raw};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (sync_last[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= DEB_LIM) begin
        cnt_d[i]   = '0;
        clean_d[i] = sync_last[i];
        rise_d[i]  = sync_last[i];
        fall_d[i]  = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
    change_d = (|rise_d) | (|fall_d);
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      clean_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign button_clean  = clean_q;
  assign button_rise   = rise_q;
  assign button_fall   = fall_q;
  assign button_change = change_q;

`ifdef BASICIO_AUTOREPEAT_EN
  localparam logic [REPEAT_WIDTH-1:0] RD_LIM = REPEAT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [REPEAT_WIDTH-1:0] RP_LIM = REPEAT_WIDTH'(REPEAT_PERIOD - 1);

  logic [NUM_BUTTONS-1:0][REPEAT_WIDTH-1:0] rcnt_q, rcnt_d;
  logic [NUM_BUTTONS-1:0]                   phase_q, phase_d;
  logic [NUM_BUTTONS-1:0]                   repeat_q, repeat_d;

  // Held-button repeat timer; phase selects initial delay vs steady period
  always_comb begin
    rcnt_d   = rcnt_q;
    phase_d  = phase_q;
    repeat_d = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (!clean_d[i] || rise_d[i]) begin
        rcnt_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (rcnt_q[i] >= (phase_q[i] ? RP_LIM : RD_LIM)) begin
        rcnt_d[i]   = '0;
        phase_d[i]  = 1'b1;
        repeat_d[i] = 1'b1;
      end else begin
        rcnt_d[i] = rcnt_q[i] + REPEAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      rcnt_q   <= '0;
      phase_q  <= '0;
      repeat_q <= '0;
    end else begin
      rcnt_q   <= rcnt_d;
      phase_q  <= phase_d;
      repeat_q <= repeat_d;
    end
  end

  assign button_repeat = repeat_q;
`else
  assign button_repeat = '0;
`endif

endmodule

// File: tb/tb_basicio_debounce.sv
// Scoreboard bench for basicio_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, NUM_BUTTONS=8).
module tb_basicio_debounce;

  localparam int unsigned LAT = 6;

  logic       hba_clk = 1'b0;
  logic       hba_reset = 1'b1;
  logic [7:0] button_raw = 8'h00;
  logic [7:0] button_clean, button_rise, button_fall, button_repeat;
  logic       button_change;

  basicio_debounce #(
    .NUM_BUTTONS    (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (18),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_WIDTH   (8)
  ) dut (
    .hba_clk      (hba_clk),
    .hba_reset    (hba_reset),
    .button_raw   (button_raw),
    .button_clean (button_clean),
    .button_rise  (button_rise),
    .button_fall  (button_fall),
    .button_change(button_change),
    .button_repeat(button_repeat)
  );

  always #5 hba_clk = ~hba_clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [7:0]  rep;
    logic [7:0]  clean;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge hba_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hba_clk);
    #1;
  endtask

  task automatic push(input int unsigned c, input logic [7:0] r, input logic [7:0] f,
                      input logic [7:0] p, input logic [7:0] cl);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.rep = p; e.clean = cl;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse on the outputs consumes one expected event
  always @(negedge hba_clk) begin
    ev_t e;
    if (button_change || (button_repeat != 8'h00)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: cyc=%0d rise=%h fall=%h rep=%h", cyc,
                 button_rise, button_fall, button_repeat);
      end else begin
        e = exp_q.pop_front();
        check("ev_cycle", 32'(cyc), 32'(e.cyc));
        check("ev_rise", 32'(button_rise), 32'(e.rise));
        check("ev_fall", 32'(button_fall), 32'(e.fall));
        check("ev_change", 32'(button_change), 32'((e.rise | e.fall) != 8'h00));
        check("ev_repeat", 32'(button_repeat), 32'(e.rep));
        check("ev_clean", 32'(button_clean), 32'(e.clean));
      end
    end
  end

  initial begin
    ev_t e;
    // Reset with all buttons pressed
    button_raw = 8'hFF;
    hba_reset  = 1'b1;
    tick(3);
    check("rst_clean", 32'(button_clean), 32'h0);
    check("rst_rise", 32'(button_rise), 32'h0);
    check("rst_fall", 32'(button_fall), 32'h0);
    check("rst_change", 32'(button_change), 32'h0);
    check("rst_repeat", 32'(button_repeat), 32'h0);
    hba_reset = 1'b0;
    push(cyc + LAT, 8'hFF, 8'h00, 8'h00, 8'hFF);
    tick(8);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'hFF, 8'h00, 8'h00);
    tick(10);

    // Single bit press and release
    button_raw = 8'h01;
    push(cyc + LAT, 8'h01, 8'h00, 8'h00, 8'h01);
    tick(8);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'h01, 8'h00, 8'h00);
    tick(10);

    // Bit2 bouncing every 2 cycles, then stable high
    for (int k = 0; k < 6; k++) begin
      button_raw[2] = (k % 2 == 0);
      tick(2);
    end
    button_raw[2] = 1'b1;
    push(cyc + LAT, 8'h04, 8'h00, 8'h00, 8'h04);
    tick(8);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'h04, 8'h00, 8'h00);
    tick(10);

    // Simultaneous bit3 rise and bit5 fall
    button_raw = 8'h20;
    push(cyc + LAT, 8'h20, 8'h00, 8'h00, 8'h20);
    tick(8);
    button_raw = 8'h08;
    push(cyc + LAT, 8'h08, 8'h20, 8'h00, 8'h08);
    tick(8);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'h08, 8'h00, 8'h00);
    tick(10);

    // Reset in the middle of a debounce count
    button_raw = 8'h02;
    tick(4);
    hba_reset = 1'b1;
    tick(1);
    check("midrst_clean", 32'(button_clean), 32'h0);
    check("midrst_rise", 32'(button_rise), 32'h0);
    tick(1);
    hba_reset = 1'b0;
    push(cyc + LAT, 8'h02, 8'h00, 8'h00, 8'h02);
    tick(8);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'h02, 8'h00, 8'h00);
    tick(10);

    // Long hold of bit0: repeats only when auto-repeat is compiled in
    button_raw = 8'h01;
    push(cyc + LAT, 8'h01, 8'h00, 8'h00, 8'h01);
`ifdef BASICIO_AUTOREPEAT_EN
    push(cyc + LAT + 10, 8'h00, 8'h00, 8'h01, 8'h01);
    push(cyc + LAT + 13, 8'h00, 8'h00, 8'h01, 8'h01);
    push(cyc + LAT + 16, 8'h00, 8'h00, 8'h01, 8'h01);
`endif
    tick(18);
    button_raw = 8'h00;
    push(cyc + LAT, 8'h00, 8'h01, 8'h00, 8'h00);
    tick(12);
    check("idle_clean", 32'(button_clean), 32'h0);
    check("idle_repeat", 32'(button_repeat), 32'h0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: cyc=%0d rise=%h fall=%h rep=%h", e.cyc, e.rise, e.fall, e.rep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
